// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause 22 MDIO PHY responder.
package mdio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ST,
        OP,
        PHYADR,
        REGADR,
        TA,
        DATA
    } mdio_state_e;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] TA_WRITE = 2'b10;

    localparam int MDIO_PREAMBLE_LEN = 32;

endpackage

// File: rtl/mdio_sync_edge.sv
// MDC/MDIN synchronizer with MDC rising-edge detect; mdin_s is aligned with mdc_rise.
module mdio_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic mdc,
    input  logic mdin,
    output logic mdc_rise,
    output logic mdin_s
);

    logic [SYNC_STAGES-1:0] mdc_q;
    logic [SYNC_STAGES-1:0] mdin_q;
    logic                   mdc_prev;

    // MDIN resets high to match an idle, pulled-up line.
    always_ff @(posedge clk) begin
        if (reset) begin
            mdc_q    <= '0;
            mdin_q   <= '1;
            mdc_prev <= 1'b0;
        end else begin
            mdc_q    <= {mdc_q[SYNC_STAGES-2:0], mdc};
            mdin_q   <= {mdin_q[SYNC_STAGES-2:0], mdin};
            mdc_prev <= mdc_q[SYNC_STAGES-1];
        end
    end

    assign mdc_rise = mdc_q[SYNC_STAGES-1] & ~mdc_prev;
    assign mdin_s   = mdin_q[SYNC_STAGES-1];

endmodule

// File: rtl/mdio_phy_responder.sv
// Clause 22 MDIO PHY-side responder with a strobe-based register port.
// Optional broadcast write acceptance (PHYADR 0) when MDIO_BCAST_EN is defined.
module mdio_phy_responder
    import mdio_pkg::*;
#(
    parameter int PREAMBLE_LEN = MDIO_PREAMBLE_LEN,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              MDC,
    input  logic              MDIN,
    output logic              MDOUT,
    output logic              MDTRI,
    input  logic [4:0]        PHYAD,
    output logic [4:0]        REG_ADDR,
    output logic              REG_RD,
    input  logic [15:0]       REG_RDDATA,
    output logic              REG_WR,
    output logic [15:0]       REG_WRDATA,
    output logic              FRAME_ERR,
    output mdio_state_e       DBG_STATE
);

    // Register port: REG_RD/REG_WR are single-CLK strobes with REG_ADDR (and
    // REG_WRDATA) valid in that cycle; REG_RDDATA is captured on the next CLK edge.
    localparam int PW = $clog2(PREAMBLE_LEN + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(PREAMBLE_LEN);

    logic              mdc_rise;
    logic              mdin_s;

    mdio_state_e       state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic [PW-1:0]     pre_cnt, pre_n;
    logic [3:0]        fsh, fsh_n;
    logic [15:0]       sh, sh_n;
    logic              is_rd, is_rd_n;
    logic              match, match_n;
    logic [4:0]        bits;
    logic              mdout_n, mdtri_n;
    logic [4:0]        reg_addr_n;
    logic              reg_rd_n, reg_wr_n;
    logic [15:0]       reg_wrdata_n;
    logic              frame_err_n;
    logic              phy_hit;

    mdio_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (CLK),
        .reset    (RESET),
        .mdc      (MDC),
        .mdin     (MDIN),
        .mdc_rise (mdc_rise),
        .mdin_s   (mdin_s)
    );

    assign bits = {fsh, mdin_s};

`ifdef MDIO_BCAST_EN
    assign phy_hit = (bits == PHYAD) || ((bits == 5'd0) && !is_rd);
`else
    assign phy_hit = (bits == PHYAD);
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            pre_cnt    <= '0;
            fsh        <= '0;
            sh         <= '0;
            is_rd      <= 1'b0;
            match      <= 1'b0;
            MDOUT      <= 1'b1;
            MDTRI      <= 1'b1;
            REG_ADDR   <= '0;
            REG_RD     <= 1'b0;
            REG_WR     <= 1'b0;
            REG_WRDATA <= '0;
            FRAME_ERR  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            pre_cnt    <= pre_n;
            fsh        <= fsh_n;
            sh         <= sh_n;
            is_rd      <= is_rd_n;
            match      <= match_n;
            MDOUT      <= mdout_n;
            MDTRI      <= mdtri_n;
            REG_ADDR   <= reg_addr_n;
            REG_RD     <= reg_rd_n;
            REG_WR     <= reg_wr_n;
            REG_WRDATA <= reg_wrdata_n;
            FRAME_ERR  <= frame_err_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        pre_n        = pre_cnt;
        fsh_n        = fsh;
        sh_n         = sh;
        is_rd_n      = is_rd;
        match_n      = match;
        mdout_n      = MDOUT;
        mdtri_n      = MDTRI;
        reg_addr_n   = REG_ADDR;
        reg_rd_n     = 1'b0;
        reg_wr_n     = 1'b0;
        reg_wrdata_n = REG_WRDATA;
        frame_err_n  = 1'b0;

        if (REG_RD) begin
            sh_n = REG_RDDATA;
        end

        if (mdc_rise) begin
            cnt_n = cnt + 4'd1;
            fsh_n = bits[3:0];
            if (mdin_s) begin
                pre_n = (pre_cnt == PRE_MAX) ? pre_cnt : pre_cnt + 1'b1;
            end else begin
                pre_n = '0;
            end

            case (state)
                IDLE: begin
                    cnt_n = '0;
                    if (!mdin_s && (pre_cnt == PRE_MAX)) begin
                        state_n = ST;
                    end
                end
                ST: begin
                    cnt_n = '0;
                    if (mdin_s) begin
                        state_n = OP;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = IDLE;
                        pre_n       = '0;
                    end
                end
                OP: begin
                    if (cnt == 4'd1) begin
                        cnt_n = '0;
                        if ((bits[1:0] == OP_READ) || (bits[1:0] == OP_WRITE)) begin
                            is_rd_n = (bits[1:0] == OP_READ);
                            state_n = PHYADR;
                        end else begin
                            frame_err_n = 1'b1;
                            state_n     = IDLE;
                            pre_n       = '0;
                        end
                    end
                end
                PHYADR: begin
                    if (cnt == 4'd4) begin
                        cnt_n   = '0;
                        match_n = phy_hit;
                        state_n = REGADR;
                    end
                end
                REGADR: begin
                    if (cnt == 4'd4) begin
                        cnt_n      = '0;
                        reg_addr_n = bits;
                        reg_rd_n   = match & is_rd;
                        state_n    = TA;
                    end
                end
                TA: begin
                    if (cnt == 4'd0) begin
                        // Second TA slot: the responder owns the line from here on.
                        if (is_rd && match) begin
                            mdtri_n = 1'b0;
                            mdout_n = 1'b0;
                        end
                    end else begin
                        cnt_n   = '0;
                        state_n = DATA;
                        if (is_rd) begin
                            sh_n = {sh[14:0], 1'b0};
                            if (match) begin
                                mdout_n = sh[15];
                            end
                        end else if (match && (bits[1:0] != TA_WRITE)) begin
                            frame_err_n = 1'b1;
                            state_n     = IDLE;
                            pre_n       = '0;
                        end
                    end
                end
                DATA: begin
                    if (is_rd) begin
                        sh_n = {sh[14:0], 1'b0};
                        if (match) begin
                            mdout_n = sh[15];
                        end
                    end else begin
                        sh_n = {sh[14:0], mdin_s};
                    end
                    if (cnt == 4'd15) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                        pre_n   = '0;
                        mdtri_n = 1'b1;
                        mdout_n = 1'b1;
                        if (!is_rd && match) begin
                            reg_wr_n     = 1'b1;
                            reg_wrdata_n = {sh[14:0], mdin_s};
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign DBG_STATE = state;

endmodule

// File: doc/mdio_phy_responder.md
# mdio_phy_responder

PHY-side MDIO management responder: the slave end of the Clause 22 serial management link driven by the Ethernet MAC's MDIO master (MCLKOUT/MDOUT/MDTRI outputs, MDIN input). It oversamples MDC in the local clock domain, decodes read and write frames addressed to its PHY address, and exposes a simple strobe-based register port to an external PHY register bank. It sits in PHY models and loopback test fixtures that face the MAC's management pins.

## Interface
- PREAMBLE_LEN, 32: minimum number of consecutive sampled 1s that arms frame detection.
- SYNC_STAGES, 2: synchronizer depth for MDC and MDIN; legal values are 2 or 3.

- CLK  in  1  system clock; frequency must be at least 4x MDC.
- RESET  in  1  synchronous, active-high reset.
- MDC  in  1  management clock from the MAC, asynchronous to CLK.
- MDIN  in  1  serial data from the MAC.
- MDOUT  out  1  serial data to the MAC. Reset value 1.
- MDTRI  out  1  1 = release the line, 0 = drive MDOUT. Reset value 1.
- PHYAD  in  5  this PHY's address; static.
- REG_ADDR  out  5  captured register address. Reset value 0.
- REG_RD  out  1  one-CLK read strobe. Reset value 0.
- REG_RDDATA  in  16  read data; sampled 1 CLK after REG_RD.
- REG_WR  out  1  one-CLK write strobe. Reset value 0.
- REG_WRDATA  out  16  write data; valid while REG_WR is high. Reset value 0.
- FRAME_ERR  out  1  one-CLK pulse on a malformed frame. Reset value 0.

## Operation
- MDC and MDIN pass through SYNC_STAGES flops. A rising edge is detected when the synchronized MDC is 1 and was 0 on the previous CLK. All bit sampling happens on that detect cycle, using the synchronized MDIN.
- Preamble counter: increments on each sampled 1 and saturates at PREAMBLE_LEN. A sampled 0 clears it. The counter also clears at the end of every frame and on any error.
- States:
  - IDLE: wait for the counter to reach PREAMBLE_LEN and then a sampled 0 → ST.
  - ST: sampled 1 → OP. Sampled 0 → FRAME_ERR, then IDLE.
  - OP: collects 2 bits. 10 = read, 01 = write; both → PHYADR. 00 or 11 → FRAME_ERR, then IDLE.
  - PHYADR: collects 5 bits, MSB first. Sets match = (bits == PHYAD).
  - REGADR: collects 5 bits. On the last bit, REG_ADDR is loaded. If this is a matching read, REG_RD pulses on the same CLK. → TA.
  - TA: 2 bits.
    - Read: MDTRI stays 1 through the first TA slot. The responder drives 0 for the second slot.
    - Write: the expected pattern is 10. A mismatch on a matching write → FRAME_ERR, and the write is suppressed.
  - DATA: 16 bits, MSB first.
    - Write: bits shift in. After the 16th bit, a matching, valid write pulses REG_WR for one CLK, with REG_WRDATA holding the shifted word.
    - Read: the shift register loads REG_RDDATA on the CLK after REG_RD and shifts out one bit per MDC edge. After the last bit → IDLE, and the preamble counter clears.
- Non-matching frames are tracked to completion: no drive, no strobes, no FRAME_ERR.
- RESET at any point: the next state is IDLE, all outputs return to their reset values, and the line is released on the CLK after RESET is sampled.

## Timing
- Edge numbering: E_ra is the MDC edge that samples REGAD[0].
- Read frame, MDTRI/MDOUT updates one CLK after each edge detect:
  - E_ra: stay released.
  - E_ra+1: drive 0 (second TA slot).
  - E_ra+2: drive D15.
  - E_ra+2+k: drive D(15-k).
  - E_ra+18: release.
- REG_RD pulses on the E_ra detect cycle. REG_RDDATA must be stable on the next CLK.
- Write frame: REG_WR pulses on the CLK after the edge detect that samples D0.
- A strobe never overlaps a frame error. REG_RD and REG_WR are never high together.

## Configuration
- MDIO_BCAST_EN defined: PHYADR 00000 also matches, for writes only. Broadcast reads are treated as non-matching: no drive and no REG_RD.
- MDIO_BCAST_EN undefined: only an exact PHYAD match is accepted.

## Structure
- Shared package mdio_pkg holds:
  - the state enum (IDLE, ST, OP, PHYADR, REGADR, TA, DATA);
  - opcode constants OP_READ = 2'b10 and OP_WRITE = 2'b01;
  - the TA_WRITE = 2'b10 constant;
  - the default preamble length.
- One sub-module, mdio_sync_edge: the synchronizer plus the rising-edge detector for MDC, with the aligned MDIN sample.

## Test plan
- Read at PHYAD=5, REG=2, REG_RDDATA=0x0141:
  - REG_RD pulses once with REG_ADDR=2.
  - MDOUT shows TA 0 and then 0000_0001_0100_0001.
  - The line is released after the last bit.
- Write at PHYAD=5, REG=0, data 0x1140, TA=10: a single REG_WR pulse with REG_ADDR=0 and REG_WRDATA=0x1140.
- Read with PHYADR=6 while PHYAD=5: MDTRI stays 1 throughout, no strobes, no FRAME_ERR.
- Preamble of 31 ones followed by a valid read: ignored. The same frame with 32 ones is answered.
- ST=00 after the preamble → one FRAME_ERR pulse. A write with TA=11 → FRAME_ERR and no REG_WR.
- RESET asserted during data bit D8 of a read: MDTRI=1 one CLK later. A following well-formed read is answered correctly.
- With MDIO_BCAST_EN: a write to PHYADR 0 produces REG_WR. Without it, the same frame produces no REG_WR.
